// File: rtl/enc4s_iter.sv
//==============================================================================
// Module : enc4s_iter
// Iterative AES/SM4 full-column round unit. It handles LANES bytes per cycle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module enc4s_iter #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [2:0]  in_fn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rd,
    output logic        out_err,
    output logic        busy
);

    localparam int         STEPS  = 4 / LANES;
    localparam logic [1:0] c_LAST = 2'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2047:0] c_SM4 = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 via an addition chain; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x14, x15, x240;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x14  = gmul(x12, x2);
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(x240, x14);
    endfunction

    function automatic logic [7:0] r8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] w, input logic [4:0] n);
        return (w << n) | (w >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [7:0] sbox(input logic [2:0] fn, input logic [7:0] x);
        logic [7:0] pre;
        logic [7:0] inv;
        if (fn == 3'd3) begin
            return c_SM4[11'd2047 - {x, 3'b000} -: 8];
        end
        pre = (fn == 3'd1) ? (r8(x, 1) ^ r8(x, 3) ^ r8(x, 6) ^ 8'h05) : x;
        inv = gf_inv(pre);
        if (fn == 3'd1) return inv;
        return inv ^ r8(inv, 1) ^ r8(inv, 2) ^ r8(inv, 3) ^ r8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] term(input logic [2:0] fn, input logic [7:0] s,
                                         input logic [1:0] idx);
        logic [31:0] w;
        logic [4:0]  sh;
        sh = {idx, 3'b000};
        w  = 32'd0;
        case (fn)
            3'd0: w = rotl32({gmul(s, 8'h03), s, s, gmul(s, 8'h02)}, sh);
            3'd1: w = rotl32({gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09),
                              gmul(s, 8'h0e)}, sh);
            3'd2: w = rotl32({24'd0, s}, sh);
            3'd3: begin
                w = rotl32({24'd0, s}, sh);
                w = w ^ rotl32(w, 5'd2) ^ rotl32(w, 5'd10) ^ rotl32(w, 5'd18)
                      ^ rotl32(w, 5'd24);
            end
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  r_step;
    logic [31:0] r_acc;
    logic [31:0] r_rs2;
    logic [2:0]  r_fn;
    logic        r_err;

    logic [31:0] w_term [LANES];
    logic [31:0] w_next;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] w_idx;
        logic [7:0] w_byte;
        assign w_idx     = 2'(int'(r_step) * LANES + l);
        assign w_byte    = r_rs2[{w_idx, 3'b000} +: 8];
        assign w_term[l] = term(r_fn, sbox(r_fn, w_byte), w_idx);
    end

    always_comb begin
        w_next = r_acc;
        for (int l = 0; l < LANES; l++) begin
            w_next = w_next ^ w_term[l];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 2'd0;
            r_acc   <= 32'd0;
            r_rs2   <= 32'd0;
            r_fn    <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= S_RUN;
                        r_step  <= 2'd0;
                        r_acc   <= in_rs1;
                        r_rs2   <= in_rs2;
                        r_fn    <= in_fn;
                        r_err   <= in_fn[2];
                    end
                end
                S_RUN: begin
                    r_acc <= w_next;
                    if (r_step == c_LAST) begin
                        r_state <= S_DONE;
                        r_step  <= 2'd0;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_rd    = r_acc;
    assign out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_enc4s_iter.sv
//==============================================================================
// Module : tb_enc4s_iter
// Runs directed and random requests on LANES=1/2/4 instances against a model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_enc4s_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [2:0]  in_fn;

    logic        ir [3];
    logic        ov [3];
    logic        oe [3];
    logic        bz [3];
    logic [31:0] rd [3];

    int LAT [3] = '{4, 2, 1};
    int n_tests = 0;
    int n_fail  = 0;

    enc4s_iter #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fn(in_fn), .out_valid(ov[0]),
        .out_ready(out_ready), .out_rd(rd[0]), .out_err(oe[0]), .busy(bz[0]));
    enc4s_iter #(.LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fn(in_fn), .out_valid(ov[1]),
        .out_ready(out_ready), .out_rd(rd[1]), .out_err(oe[1]), .busy(bz[1]));
    enc4s_iter #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_fn(in_fn), .out_valid(ov[2]),
        .out_ready(out_ready), .out_rd(rd[2]), .out_err(oe[2]), .busy(bz[2]));

    localparam logic [2047:0] c_SM4_REF = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];
    logic [7:0] sb    [256];
    logic [7:0] isb   [256];
    logic [7:0] sm4   [256];

    // Log/antilog tables over generator 3, then S-boxes from inverse + affine.
    task automatic init_tables();
        logic [7:0]    x;
        logic [7:0]    inv;
        logic [7:0]    c;
        logic [7:0]    b;
        logic [2047:0] t;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
        end
        c = 8'h63;
        for (int v = 0; v < 256; v++) begin
            inv = (v == 0) ? 8'h00 : exp_t[(255 - int'(log_t[v])) % 255];
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[v]  = b;
            isb[b] = 8'(v);
        end
        t = c_SM4_REF;
        for (int v = 0; v < 256; v++) sm4[v] = t[2047 - 8 * v -: 8];
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] w, input int k);
        logic [63:0] d;
        d = {w, w} << k;
        return d[63:32];
    endfunction

    function automatic logic [31:0] model(input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [2:0] fn);
        logic [31:0] acc;
        logic [31:0] w;
        logic [7:0]  s;
        logic [7:0]  x;
        acc = rs1;
        if (fn >= 3'd4) return acc;
        for (int i = 0; i < 4; i++) begin
            x = rs2[8 * i +: 8];
            s = (fn == 3'd1) ? isb[x] : (fn == 3'd3) ? sm4[x] : sb[x];
            case (fn)
                3'd0:    w = rot({mul(s, 8'h03), s, s, mul(s, 8'h02)}, 8 * i);
                3'd1:    w = rot({mul(s, 8'h0b), mul(s, 8'h0d), mul(s, 8'h09),
                                  mul(s, 8'h0e)}, 8 * i);
                3'd2:    w = {24'd0, s} << (8 * i);
                default: begin
                    w = {24'd0, s} << (8 * i);
                    w = w ^ rot(w, 2) ^ rot(w, 10) ^ rot(w, 18) ^ rot(w, 24);
                end
            endcase
            acc = acc ^ w;
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] fn,
                         input logic [31:0] exp_rd, input logic exp_err, input int hold);
        for (int d = 0; d < 3; d++) chk($sformatf("in_ready_idle[%0d]", d), 32'(ir[d]), 32'd1);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_fn    = fn;
        tick();
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_fn    = 3'($urandom);
        for (int c = 1; c <= 4 + hold; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("out_valid[%0d]c%0d", d, c), 32'(ov[d]), 32'(c >= LAT[d]));
                chk($sformatf("in_ready_busy[%0d]c%0d", d, c), 32'(ir[d]), 32'd0);
                chk($sformatf("busy[%0d]c%0d", d, c), 32'(bz[d]), 32'd1);
                if (c >= LAT[d]) begin
                    chk($sformatf("out_rd[%0d]c%0d", d, c), rd[d], exp_rd);
                    chk($sformatf("out_err[%0d]c%0d", d, c), 32'(oe[d]), 32'(exp_err));
                end
            end
        end
        // A request offered during the retire cycle must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("retire_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("retire_busy[%0d]", d), 32'(bz[d]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r1, r2;
        logic [2:0]  f;
        init_tables();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_rs1 = 32'd0; in_rs2 = 32'd0; in_fn = 3'd0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_rd[%0d]", d), rd[d], 32'd0);
            chk($sformatf("rst_err[%0d]", d), 32'(oe[d]), 32'd0);
            chk($sformatf("rst_ready[%0d]", d), 32'(ir[d]), 32'd1);
            chk($sformatf("rst_busy[%0d]", d), 32'(bz[d]), 32'd0);
        end
        rst_n = 1'b1;

        do_op(32'h0, 32'h0, 3'd2, 32'h63636363, 1'b0, 0);
        do_op(32'h01234567, 32'h00000001, 3'd2, 32'h6240261b, 1'b0, 0);
        do_op(32'h0, 32'h0, 3'd0, 32'h63636363, 1'b0, 0);
        do_op(32'h0, 32'h0, 3'd1, 32'h52525252, 1'b0, 0);
        do_op(32'h0, 32'h0, 3'd3, 32'h5b5b5b5b, 1'b0, 3);
        do_op(32'hdeadbeef, $urandom, 3'd5, 32'hdeadbeef, 1'b1, 1);

        // Reset while the LANES=1 instance is at step 2.
        in_valid = 1'b1; in_rs1 = 32'h0; in_rs2 = 32'h0; in_fn = 3'd2;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            for (int d = 0; d < 3; d++)
                chk($sformatf("pre_rst_valid[%0d]c%0d", d, c), 32'(ov[d]), 32'(c >= LAT[d]));
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid_rst_ready[%0d]", d), 32'(ir[d]), 32'd1);
            chk($sformatf("mid_rst_valid[%0d]", d), 32'(ov[d]), 32'd0);
            chk($sformatf("mid_rst_rd[%0d]", d), rd[d], 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("dropped_valid_c%0d", c), 32'(ov[0]), 32'd0);
        end

        for (int n = 0; n < 24; n++) begin
            r1 = $urandom;
            r2 = $urandom;
            f  = 3'($urandom_range(0, 7));
            do_op(r1, r2, f, model(r1, r2, f), f[2], int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
